// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control from decode, instruction-memory port, and the
// aligned {pc, instr, valid} triple handed to decode.
interface fetch_unit_if #(
    parameter int PC_WIDTH = 10
);
    logic                stall;
    logic                redirect;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                halt;
    logic [PC_WIDTH-1:0] imem_pc;
    logic [31:0]         imem_instr;
    logic [PC_WIDTH-1:0] id_pc;
    logic [PC_WIDTH-1:0] id_pc_plus1;
    logic [31:0]         id_instr;
    logic                id_valid;
    logic                halted;
    logic [15:0]         fetch_count;

    modport master (
        input  stall, redirect, redirect_pc, halt, imem_instr,
        output imem_pc, id_pc, id_pc_plus1, id_instr, id_valid, halted, fetch_count
    );

    modport slave (
        output stall, redirect, redirect_pc, halt, imem_instr,
        input  imem_pc, id_pc, id_pc_plus1, id_instr, id_valid, halted, fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// PC / fetch control ahead of a synchronous instruction memory. id_pc tracks
// the address whose data is currently on the memory's registered output.
module fetch_unit #(
    parameter int                   PC_WIDTH = 10,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0,
    parameter logic [31:0]          NOP_WORD = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_e;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] id_pc_q, next_pc;
    logic                id_valid_q, id_valid_d;
    logic                halted_q, halted_d;
    logic [15:0]         count_q, count_d;
    logic                load_new;

    always_comb begin
        state_d    = state_q;
        next_pc    = id_pc_q;
        id_valid_d = id_valid_q;
        halted_d   = halted_q;
        load_new   = 1'b0;
        unique case (state_q)
            BOOT: begin
                next_pc    = RESET_PC;
                state_d    = RUN;
                id_valid_d = 1'b1;
                load_new   = 1'b1;
            end
            RUN: begin
                id_valid_d = 1'b1;
                if (bus.halt) begin
                    state_d    = HALTED;
                    id_valid_d = 1'b0;
                    halted_d   = 1'b1;
                end else if (bus.redirect) begin
                    // redirect beats stall: the stalled instruction is dropped
                    next_pc  = bus.redirect_pc;
                    load_new = 1'b1;
                end else if (!bus.stall) begin
                    next_pc  = id_pc_q + 1'b1;
                    load_new = 1'b1;
                end
            end
            default: begin
                id_valid_d = 1'b0;
            end
        endcase
        count_d = (load_new && count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            id_pc_q    <= RESET_PC;
            id_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            id_pc_q    <= next_pc;
            id_valid_q <= id_valid_d;
            halted_q   <= halted_d;
            count_q    <= count_d;
        end
    end

    // BOOT already selects RESET_PC, so the address is correct while rst is held
    assign bus.imem_pc     = next_pc;
    assign bus.id_pc       = id_pc_q;
    assign bus.id_pc_plus1 = id_pc_q + 1'b1;
    assign bus.id_instr    = id_valid_q ? bus.imem_instr : NOP_WORD;
    assign bus.id_valid    = id_valid_q;
    assign bus.halted      = halted_q;
    assign bus.fetch_count = count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a synchronous memory model and a
// scoreboard of expected decode-side outputs.
module tb_fetch_unit;
    localparam int PC_W = 10;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic            valid;
        logic            halted;
        logic [15:0]     cnt;
    } exp_t;
    exp_t sb[$];

    fetch_unit_if #(.PC_WIDTH(PC_W)) bus ();

    fetch_unit #(.PC_WIDTH(PC_W), .RESET_PC('0), .NOP_WORD(NOP)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [PC_W-1:0] a);
        return 32'hC0DE_0000 | {22'd0, a};
    endfunction

    always @(posedge clk) bus.imem_instr <= word(bus.imem_pc);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic st, input logic rd, input logic [PC_W-1:0] rpc, input logic hl);
        bus.stall       = st;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.halt        = hl;
    endtask

    // Drive one cycle's controls, check the combinational address, queue the
    // expected post-edge view, then compare it after the edge.
    task automatic cyc(input logic st, input logic rd, input logic [PC_W-1:0] rpc, input logic hl,
                       input logic [PC_W-1:0] exp_n, input logic exp_v, input logic exp_h,
                       input logic [15:0] exp_cnt);
        exp_t e;
        logic [PC_W-1:0] p1;
        drive(st, rd, rpc, hl);
        #1;
        chk("imem_pc", {22'd0, bus.imem_pc}, {22'd0, exp_n});
        e.pc = exp_n; e.valid = exp_v; e.halted = exp_h; e.cnt = exp_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e  = sb.pop_front();
            p1 = e.pc + 10'd1;
            chk("id_pc", {22'd0, bus.id_pc}, {22'd0, e.pc});
            chk("id_pc_plus1", {22'd0, bus.id_pc_plus1}, {22'd0, p1});
            chk("id_instr", bus.id_instr, e.valid ? word(e.pc) : NOP);
            chk("id_valid", {31'd0, bus.id_valid}, {31'd0, e.valid});
            chk("halted", {31'd0, bus.halted}, {31'd0, e.halted});
            chk("fetch_count", {16'd0, bus.fetch_count}, {16'd0, e.cnt});
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_id_pc"}, {22'd0, bus.id_pc}, 32'd0);
        chk({tag, "_imem_pc"}, {22'd0, bus.imem_pc}, 32'd0);
        chk({tag, "_valid"}, {31'd0, bus.id_valid}, 32'd0);
        chk({tag, "_halted"}, {31'd0, bus.halted}, 32'd0);
        chk({tag, "_count"}, {16'd0, bus.fetch_count}, 32'd0);
        chk({tag, "_instr"}, bus.id_instr, NOP);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        drive(1'b1, 1'b1, 10'd77, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        @(negedge clk);
        rst = 1'b0;

        // boot ignores controls, then free run
        cyc(1, 1, 10'd77, 1, 10'd0, 1, 0, 16'd1);
        cyc(0, 0, 10'd0, 0, 10'd1, 1, 0, 16'd2);
        cyc(0, 0, 10'd0, 0, 10'd2, 1, 0, 16'd3);
        cyc(0, 0, 10'd0, 0, 10'd3, 1, 0, 16'd4);
        cyc(0, 0, 10'd0, 0, 10'd4, 1, 0, 16'd5);
        cyc(0, 0, 10'd0, 0, 10'd5, 1, 0, 16'd6);
        // stall three cycles at id_pc=5
        cyc(1, 0, 10'd0, 0, 10'd5, 1, 0, 16'd6);
        cyc(1, 0, 10'd0, 0, 10'd5, 1, 0, 16'd6);
        cyc(1, 0, 10'd0, 0, 10'd5, 1, 0, 16'd6);
        cyc(0, 0, 10'd0, 0, 10'd6, 1, 0, 16'd7);
        cyc(0, 0, 10'd0, 0, 10'd7, 1, 0, 16'd8);
        // redirect at id_pc=7, without then with stall
        cyc(0, 1, 10'd200, 0, 10'd200, 1, 0, 16'd9);
        cyc(0, 0, 10'd0, 0, 10'd201, 1, 0, 16'd10);
        cyc(0, 1, 10'd7, 0, 10'd7, 1, 0, 16'd11);
        cyc(1, 1, 10'd200, 0, 10'd200, 1, 0, 16'd12);
        // wrap at the top of the address space
        cyc(1, 1, 10'd1023, 0, 10'd1023, 1, 0, 16'd13);
        cyc(0, 0, 10'd0, 0, 10'd0, 1, 0, 16'd14);
        cyc(0, 0, 10'd0, 0, 10'd1, 1, 0, 16'd15);
        // halt together with redirect at id_pc=11
        cyc(0, 1, 10'd11, 0, 10'd11, 1, 0, 16'd16);
        cyc(0, 1, 10'd500, 1, 10'd11, 0, 1, 16'd16);
        cyc(0, 1, 10'd300, 0, 10'd11, 0, 1, 16'd16);
        cyc(1, 0, 10'd0, 1, 10'd11, 0, 1, 16'd16);
        cyc(0, 0, 10'd0, 0, 10'd11, 0, 1, 16'd16);

        // reset out of HALTED, run, then async reset in the middle of a stall
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset("rst_halted");
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, 10'd0, 0, 10'd0, 1, 0, 16'd1);
        cyc(0, 0, 10'd0, 0, 10'd1, 1, 0, 16'd2);
        cyc(0, 0, 10'd0, 0, 10'd2, 1, 0, 16'd3);
        drive(1'b1, 1'b0, 10'd0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_reset("rst_async");
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, 10'd0, 0, 10'd0, 1, 0, 16'd1);
        cyc(0, 0, 10'd0, 0, 10'd1, 1, 0, 16'd2);

        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
